// File: rtl/high_score_keeper_if.sv
// high_score_keeper_if
//   Groups the game-event inputs and the score/result outputs of
//   high_score_keeper. clk and rst stay plain ports on the module.
//
//   Signal semantics: every input is a single-cycle pulse (clear_high may
//   also be held as a level). Inputs are sampled on the rising edge of clk
//   and act only in the state that accepts them. There is no back-pressure.
//   newHighScore / died are registered one-cycle pulses and are never high
//   together.
//
//   master : drives the game events and observes the outputs (stimulus side)
//   slave  : the keeper itself
interface high_score_keeper_if;
    logic       game_start;
    logic       point;
    logic       hit;
    logic       clear_high;
    logic [3:0] score_tens;
    logic [3:0] score_ones;
    logic [3:0] high_tens;
    logic [3:0] high_ones;
    logic       playing;
    logic       newHighScore;
    logic       died;
    logic [1:0] state_dbg;   // current FSM state, for observation only

    modport master (
        output game_start, point, hit, clear_high,
        input  score_tens, score_ones, high_tens, high_ones,
        input  playing, newHighScore, died, state_dbg
    );

    modport slave (
        input  game_start, point, hit, clear_high,
        output score_tens, score_ones, high_tens, high_ones,
        output playing, newHighScore, died, state_dbg
    );
endinterface

// File: rtl/high_score_keeper.sv
// high_score_keeper
//   Keeps the running two-digit BCD score of the current game and the session
//   high score. When a game ends it emits exactly one single-cycle pulse:
//   newHighScore if the final score strictly beats the stored high score,
//   otherwise died.
//
// Ports:
//   clk  - system clock, all state changes on the rising edge
//   rst  - synchronous, active-high reset
//   hs   - high_score_keeper_if.slave:
//            game_start, point, hit, clear_high  (inputs)
//            score_tens/ones, high_tens/ones      (BCD digits, registered)
//            playing, newHighScore, died          (registered flags/pulses)
//            state_dbg                            (current FSM state)
module high_score_keeper #(
    parameter logic [3:0] HIGH_INIT_TENS = 4'd0,
    parameter logic [3:0] HIGH_INIT_ONES = 4'd0
) (
    input logic               clk,
    input logic               rst,
    high_score_keeper_if.slave hs
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        COMPARE = 2'd2,
        REPORT  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] score_tens_q, score_tens_d;
    logic [3:0] score_ones_q, score_ones_d;
    logic [3:0] high_tens_q, high_tens_d;
    logic [3:0] high_ones_q, high_ones_d;
    logic       playing_q, playing_d;
    logic       new_high_q, new_high_d;
    logic       died_q, died_d;

    logic       score_at_max;
    logic       score_beats_high;

    assign score_at_max = (score_tens_q == 4'd9) && (score_ones_q == 4'd9);

    // BCD digits order the same way as the numbers they encode, so the
    // packed {tens,ones} byte can be compared directly as unsigned.
    assign score_beats_high = {score_tens_q, score_ones_q} > {high_tens_q, high_ones_q};

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        score_tens_d = score_tens_q;
        score_ones_d = score_ones_q;
        high_tens_d  = high_tens_q;
        high_ones_d  = high_ones_q;
        new_high_d   = 1'b0;
        died_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (hs.clear_high) begin
                    high_tens_d = HIGH_INIT_TENS;
                    high_ones_d = HIGH_INIT_ONES;
                end
                if (hs.game_start) begin
                    score_tens_d = 4'd0;
                    score_ones_d = 4'd0;
                    state_d      = PLAY;
                end
            end

            PLAY: begin
                // A point arriving with hit is still counted: the compare
                // happens one cycle later on the registered score.
                if (hs.point && !score_at_max) begin
                    if (score_ones_q == 4'd9) begin
                        score_ones_d = 4'd0;
                        score_tens_d = score_tens_q + 4'd1;
                    end else begin
                        score_ones_d = score_ones_q + 4'd1;
                    end
                end
                if (hs.hit) begin
                    state_d = COMPARE;
                end
            end

            COMPARE: begin
                if (score_beats_high) begin
                    high_tens_d = score_tens_q;
                    high_ones_d = score_ones_q;
                    new_high_d  = 1'b1;
                end else begin
                    died_d = 1'b1;
                end
                state_d = REPORT;
            end

            REPORT: begin
                // Pulse is visible during this cycle; defaults clear it.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        playing_d = (state_d == PLAY);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            score_tens_q <= 4'd0;
            score_ones_q <= 4'd0;
            high_tens_q  <= HIGH_INIT_TENS;
            high_ones_q  <= HIGH_INIT_ONES;
            playing_q    <= 1'b0;
            new_high_q   <= 1'b0;
            died_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_tens_q <= score_tens_d;
            score_ones_q <= score_ones_d;
            high_tens_q  <= high_tens_d;
            high_ones_q  <= high_ones_d;
            playing_q    <= playing_d;
            new_high_q   <= new_high_d;
            died_q       <= died_d;
        end
    end

    assign hs.score_tens   = score_tens_q;
    assign hs.score_ones   = score_ones_q;
    assign hs.high_tens    = high_tens_q;
    assign hs.high_ones    = high_ones_q;
    assign hs.playing      = playing_q;
    assign hs.newHighScore = new_high_q;
    assign hs.died         = died_q;
    assign hs.state_dbg    = state_q;

endmodule

// File: tb/tb_high_score_keeper.sv
// Bench for high_score_keeper. A game-level reference model (integer score,
// integer high score, scheduled result cycle) predicts every output after
// every clock edge.
module tb_high_score_keeper;

    logic clk;
    logic rst;
    high_score_keeper_if bus ();

    high_score_keeper dut (
        .clk (clk),
        .rst (rst),
        .hs  (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    localparam int HIGH_INIT = 0;   // DUT uses default init digits 0,0

    int cyc       = 0;
    int m_score   = 0;
    int m_high    = HIGH_INIT;
    bit m_play    = 1'b0;
    bit m_ended   = 1'b0;   // game over, result not yet finished reporting
    int m_pulse_at = -1;
    int m_idle_at  = -1;
    bit m_nhs     = 1'b0;
    bit m_died    = 1'b0;
    int pulses_seen = 0;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic model_edge(input bit r, gs, pt, ht, ch);
        cyc++;
        m_nhs  = 1'b0;
        m_died = 1'b0;
        if (r) begin
            m_score = 0;
            m_high  = HIGH_INIT;
            m_play  = 1'b0;
            m_ended = 1'b0;
        end else if (m_ended) begin
            // Result decided one edge after hit, back to idle one edge later.
            if (cyc == m_pulse_at) begin
                if (m_score > m_high) begin
                    m_high = m_score;
                    m_nhs  = 1'b1;
                end else begin
                    m_died = 1'b1;
                end
            end else if (cyc == m_idle_at) begin
                m_ended = 1'b0;
            end
        end else if (m_play) begin
            if (pt && m_score < 99) m_score++;
            if (ht) begin
                m_play     = 1'b0;
                m_ended    = 1'b1;
                m_pulse_at = cyc + 1;
                m_idle_at  = cyc + 2;
            end
        end else begin
            if (ch) m_high = HIGH_INIT;
            if (gs) begin
                m_score = 0;
                m_play  = 1'b1;
            end
        end
    endtask

    // ---------------- comparison ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".score"}, {bus.score_tens, bus.score_ones}, to_bcd(m_score));
        chk({tag, ".high"},  {bus.high_tens, bus.high_ones},   to_bcd(m_high));
        chk({tag, ".playing"}, {7'd0, bus.playing},      {7'd0, m_play});
        chk({tag, ".newHighScore"}, {7'd0, bus.newHighScore}, {7'd0, m_nhs});
        chk({tag, ".died"}, {7'd0, bus.died}, {7'd0, m_died});
        if (bus.newHighScore === 1'b1 || bus.died === 1'b1) pulses_seen++;
    endtask

    // ---------------- driver ----------------
    task automatic step(input string tag, input bit r, gs, pt, ht, ch);
        rst            = r;
        bus.game_start = gs;
        bus.point      = pt;
        bus.hit        = ht;
        bus.clear_high = ch;
        @(posedge clk);
        #1;
        rst            = 1'b0;
        bus.game_start = 1'b0;
        bus.point      = 1'b0;
        bus.hit        = 1'b0;
        bus.clear_high = 1'b0;
        model_edge(r, gs, pt, ht, ch);
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0);
    endtask

    task automatic points(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 1, 0, 0);
    endtask

    // Full game: start, n points, hit, then let the result report.
    task automatic game(input string tag, input int n);
        step(tag, 0, 1, 0, 0, 0);
        points(tag, n);
        step(tag, 0, 0, 0, 1, 0);
        idle(tag, 2);
    endtask

    // ---------------- stimulus ----------------
    int p0;

    initial begin
        rst = 1'b0;
        bus.game_start = 1'b0;
        bus.point      = 1'b0;
        bus.hit        = 1'b0;
        bus.clear_high = 1'b0;
        #2;

        // Reset state
        step("reset", 1, 0, 0, 0, 0);
        idle("reset_idle", 2);

        // First game, 3 points: record against 00 -> high 03
        step("g1_start", 0, 1, 0, 0, 0);
        points("g1_pt", 3);
        step("g1_hit", 0, 0, 0, 1, 0);
        step("g1_pulse", 0, 0, 0, 0, 0);
        chk("g1_nhs_const", {7'd0, bus.newHighScore}, 8'd1);
        chk("g1_high_const", {bus.high_tens, bus.high_ones}, 8'h03);
        step("g1_report_end", 0, 0, 0, 0, 0);
        chk("g1_nhs_low", {7'd0, bus.newHighScore}, 8'd0);

        // Equal score is not a record -> died
        game("g2_equal", 3);

        // BCD carry and saturation at 99
        step("g3_start", 0, 1, 0, 0, 0);
        points("g3_pt", 9);
        chk("g3_score09", {bus.score_tens, bus.score_ones}, 8'h09);
        points("g3_carry", 1);
        chk("g3_score10", {bus.score_tens, bus.score_ones}, 8'h10);
        points("g3_sat", 95);
        chk("g3_score99", {bus.score_tens, bus.score_ones}, 8'h99);
        step("g3_hit", 0, 0, 0, 1, 0);
        idle("g3_report", 2);

        // point and hit together at score 02 with high 02
        step("g4_reset", 1, 0, 0, 0, 0);
        game("g4_first", 2);
        step("g4_start", 0, 1, 0, 0, 0);
        points("g4_pt", 2);
        step("g4_pt_hit", 0, 0, 1, 1, 0);
        idle("g4_report", 2);

        // clear_high in IDLE, ignored in PLAY
        step("g5_reset", 1, 0, 0, 0, 0);
        game("g5_45", 45);
        step("g5_clear", 0, 0, 0, 0, 1);
        game("g5_05", 5);
        step("g5_start", 0, 1, 0, 0, 0);
        step("g5_clear_play", 0, 0, 0, 0, 1);
        step("g5_pt", 0, 0, 1, 0, 0);
        step("g5_hit", 0, 0, 0, 1, 0);
        idle("g5_report", 2);

        // rst during COMPARE drops the pulse
        p0 = pulses_seen;
        step("g6_start", 0, 1, 0, 0, 0);
        points("g6_pt", 4);
        step("g6_hit", 0, 0, 0, 1, 0);
        step("g6_rst_compare", 1, 0, 0, 0, 0);
        idle("g6_after", 3);
        chk("g6_no_pulse", 8'(pulses_seen - p0), 8'd0);

        // point / hit in IDLE do nothing
        step("idle_pt", 0, 0, 1, 0, 0);
        step("idle_hit", 0, 0, 0, 1, 0);
        idle("idle_after", 2);

        // Randomized games with noise on ignored inputs
        for (int g = 0; g < 40; g++) begin
            int n_idle, n_play;
            n_idle = $urandom_range(0, 3);
            for (int i = 0; i < n_idle; i++)
                step("rnd_idle", 0, 0, $urandom_range(0, 1), $urandom_range(0, 1),
                     ($urandom_range(0, 7) == 0));
            step("rnd_start", 0, 1, 0, 0, ($urandom_range(0, 7) == 0));
            n_play = $urandom_range(0, 30);
            for (int i = 0; i < n_play; i++)
                step("rnd_play", ($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 2) != 0), 0, ($urandom_range(0, 9) == 0));
            step("rnd_hit", 0, $urandom_range(0, 1), $urandom_range(0, 1), 1, $urandom_range(0, 1));
            step("rnd_cmp", ($urandom_range(0, 19) == 0), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            step("rnd_rep", ($urandom_range(0, 19) == 0), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        end
        idle("final", 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/high_score_keeper.md
# high_score_keeper

Upstream stage of the face-display block. Keeps the running two-digit BCD score for the current game and the session high score. At game end it issues exactly one single-cycle pulse: `newHighScore` if the final score strictly beats the stored high score, otherwise `died`. These pulses feed the face block's `newHighScore`/`died` inputs directly. The score digits also drive the score display.

## Interface
Parameters:
- `HIGH_INIT_TENS`, default 4'd0: high-score tens digit loaded on reset and on `clear_high`.
- `HIGH_INIT_ONES`, default 4'd0: high-score ones digit loaded on reset and on `clear_high`.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; one clock, reset is synchronous and active-high.
- `game_start`  in  1  single-cycle pulse; begins a game.
- `point`  in  1  single-cycle pulse; score +1.
- `hit`  in  1  single-cycle pulse; player died, game over.
- `clear_high`  in  1  level/pulse; resets high score to init value.
- `score_tens`  out  4  current score tens digit, BCD.
- `score_ones`  out  4  current score ones digit, BCD.
- `high_tens`  out  4  high score tens digit, BCD.
- `high_ones`  out  4  high score ones digit, BCD.
- `playing`  out  1  high while in PLAY.
- `newHighScore`  out  1  one-cycle pulse: game ended with a new record.
- `died`  out  1  one-cycle pulse: game ended without a new record.

## Operation
- All outputs are registered.
- Reset values:
  - score = 00.
  - high = {HIGH_INIT_TENS, HIGH_INIT_ONES}.
  - `playing`, `newHighScore`, `died` = 0.
  - state = IDLE.
- FSM states: IDLE, PLAY, COMPARE, REPORT. Unused encodings go to IDLE.
- IDLE:
  - `clear_high`=1 → high <= init value.
  - `game_start`=1 → score <= 00, go to PLAY.
  - Both may act in the same cycle.
  - `point` and `hit` are ignored.
- PLAY:
  - `playing`=1.
  - `point` → BCD increment. Ones 9 wraps to 0 with tens +1.
  - Score saturates at 99; further points are ignored.
  - `hit` → go to COMPARE.
  - `point` and `hit` in the same cycle: the point is counted before the compare.
  - `game_start` and `clear_high` are ignored.
- COMPARE (1 cycle), with `playing`=0:
  - Compares the 8-bit value {tens,ones} unsigned. BCD ordering equals numeric ordering.
  - score > high → high <= score, `newHighScore` <= 1.
  - Otherwise (including equal) → `died` <= 1.
  - Go to REPORT.
- REPORT (1 cycle):
  - Pulse output visible this cycle.
  - Pulse cleared at the next edge; go to IDLE.
  - Score digits keep the final score until the next `game_start`.
- `newHighScore` and `died` are never high simultaneously. Each is high for exactly one cycle per game.
- All inputs are ignored in COMPARE and REPORT.
- `rst` mid-game, including in COMPARE or REPORT:
  - Returns everything to reset values on that edge.
  - Any pending or active pulse is dropped.
  - The high score reverts to the init value.
- Inputs are assumed synchronous to `clk` and already edge-detected by the button stage.

## Timing
- `hit` sampled at edge N → state = COMPARE after N.
  - Edge N+1: pulse and high update appear.
  - Edge N+2: pulse low, state = IDLE.
  - Latency from `hit` to pulse is 2 cycles; pulse width is 1 cycle.
- `point` sampled at edge N → new score visible after edge N.
- `game_start` sampled at edge N → `playing`=1 and score=00 after edge N.
- Minimum game length is `game_start` → `hit` on the next cycle, which gives score 00.
- Downstream face block samples the pulses only in its idle state. Games shorter than its display time can drop a face; this is accepted behaviour.

## Test plan
- Reset with init 00; `game_start`; 3×`point`; `hit` → 2 cycles later `newHighScore`=1 for one cycle, high=03, `died`=0, IDLE after.
- High=03; new game; 3 points; `hit` → `died` pulse for one cycle, high stays 03 (equal is not a record).
- Score 09; `point` → score 10. 95 more points → score saturates at 99. `hit` → high=99, `newHighScore` pulse.
- `point` and `hit` on the same cycle at score 02 with high 02 → score 03, `newHighScore` pulse, high=03.
- In IDLE with high=45: `clear_high` → high=00. Assert `clear_high` during PLAY → no change.
- `rst` asserted in COMPARE → next cycle all outputs at reset values, no pulse ever appears. `point`/`hit` while IDLE → no score change and no pulse.
